ym_multi_ctrl: RTL and testbench

Parametrised N-chip YM2149/AY bus controller for the ZX-Spectrum sound board, successor to the dual-chip TurboSound glue. It decodes Z80 I/O cycles into BC1/BDIR, selects 1 to 4 sound chips through TurboSound-style selector writes, and latches the #FE beeper, tape and border bits. It also measures the INT frame period to choose the chip clock automatically: cpu_clock when the CPU runs at 3.5 MHz, cpu_clock/2 when it runs in turbo at 7 MHz.

---
 rtl/ym_multi_ctrl.sv | 148 ++++++++++++++
 tb/tb_ym_multi_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ym_multi_ctrl.sv
// N-chip AY/YM bus glue: combinational BC1/BDIR decode, TurboSound chip select, #FE latch, auto turbo clock.
// Latches update 1-2 falling edges after a strobe asserts; turbo follows two agreeing frame measurements.
module ym_multi_ctrl #(
  parameter int NUM_CHIPS    = 2,
  parameter int CNT_W        = 18,
  parameter int FRAME_THRESH = 107520
) (
  input  logic                 cpu_clock,
  input  logic                 reset,
  input  logic                 a0,
  input  logic                 a1,
  input  logic                 a14,
  input  logic                 a15,
  input  logic                 m1,
  input  logic                 iorq,
  input  logic                 wr,
  input  logic                 int_n,
  input  logic [7:0]           d,
  output logic                 bc1,
  output logic                 bdir,
  output logic                 ioge_c,
  output logic                 ym_clock,
  output logic [NUM_CHIPS-1:0] ym_sel_n,
  output logic                 beeper,
  output logic                 tapeout,
  output logic [2:0]           border,
  output logic                 turbo
);

  localparam int SEL_W = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;

  logic ssg, aw, fe;

  assign ssg    = ~(a15 & ~a1 & ~iorq);
  assign bc1    = ~ssg & a14 & m1;
  assign bdir   = ~ssg & ~wr;
  assign ioge_c = bc1 | bdir;
  assign aw     = bc1 & bdir;
  assign fe     = ~iorq & ~wr & ~a0;

  logic [1:0]       aw_hist_q, aw_hist_d;
  logic [1:0]       fe_hist_q, fe_hist_d;
  logic [7:0]       d_q, d_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             beeper_q, beeper_d;
  logic             tapeout_q, tapeout_d;
  logic [2:0]       border_q, border_d;
  logic [1:0]       int_sync_q, int_sync_d;
  logic             int_prev_q, int_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_cand_q, prev_cand_d;
  logic             pend_q, pend_d;
  logic             div2_q, div2_d;
  logic             turbo_q, turbo_d;

  logic       frame_mark;
  logic       cand;
  logic [1:0] k;

  always_comb begin
    aw_hist_d   = {aw_hist_q[0], aw};
    fe_hist_d   = {fe_hist_q[0], fe};
    d_d         = d;
    sel_d       = sel_q;
    beeper_d    = beeper_q;
    tapeout_d   = tapeout_q;
    border_d    = border_q;
    int_sync_d  = {int_sync_q[0], int_n};
    int_prev_d  = int_sync_q[1];
    prev_cand_d = prev_cand_q;
    pend_d      = pend_q;
    div2_d      = ~div2_q;
    // d[7:2] all ones makes 8'hFF - d equal to the inverted low two bits
    k           = ~d_q[1:0];
    frame_mark  = int_prev_q & ~int_sync_q[1];
    cand        = (cnt_q >= CNT_W'(FRAME_THRESH));
    cnt_d       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    if (aw_hist_q == 2'b01 && d_q[7:2] == 6'h3F && {1'b0, k} < 3'(NUM_CHIPS)) begin
      sel_d = SEL_W'(k);
    end

    if (fe_hist_q == 2'b01) begin
      beeper_d  = d_q[4];
      tapeout_d = d_q[3];
      border_d  = d_q[2:0];
    end

    if (frame_mark) begin
      cnt_d       = '0;
      prev_cand_d = cand;
      if (cand == prev_cand_q) begin
        pend_d = cand;
      end
    end

    // Switch only as div2 falls, so both clock sources are low at the mux change
    turbo_d = div2_q ? pend_q : turbo_q;
  end

  always_ff @(negedge cpu_clock or negedge reset) begin
    if (!reset) begin
      aw_hist_q   <= '0;
      fe_hist_q   <= '0;
      d_q         <= '0;
      sel_q       <= '0;
      beeper_q    <= 1'b0;
      tapeout_q   <= 1'b0;
      border_q    <= '0;
      int_sync_q  <= '0;
      int_prev_q  <= 1'b0;
      cnt_q       <= '0;
      prev_cand_q <= 1'b0;
      pend_q      <= 1'b0;
      div2_q      <= 1'b0;
      turbo_q     <= 1'b0;
    end else begin
      aw_hist_q   <= aw_hist_d;
      fe_hist_q   <= fe_hist_d;
      d_q         <= d_d;
      sel_q       <= sel_d;
      beeper_q    <= beeper_d;
      tapeout_q   <= tapeout_d;
      border_q    <= border_d;
      int_sync_q  <= int_sync_d;
      int_prev_q  <= int_prev_d;
      cnt_q       <= cnt_d;
      prev_cand_q <= prev_cand_d;
      pend_q      <= pend_d;
      div2_q      <= div2_d;
      turbo_q     <= turbo_d;
    end
  end

  always_comb begin
    ym_sel_n = '1;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      ym_sel_n[i] = (sel_q != SEL_W'(i));
    end
  end

  assign beeper   = beeper_q;
  assign tapeout  = tapeout_q;
  assign border   = border_q;
  assign turbo    = turbo_q;
  assign ym_clock = turbo_q ? div2_q : cpu_clock;

endmodule

// File: tb/tb_ym_multi_ctrl.sv
// Directed bench for ym_multi_ctrl; frame timing is scaled down (threshold 300, 10-bit counter).
module tb_ym_multi_ctrl;

  logic       cpu_clock, reset;
  logic       a0, a1, a14, a15, m1, iorq, wr, int_n;
  logic [7:0] d;
  logic       bc1, bdir, ioge_c, ym_clock, beeper, tapeout, turbo;
  logic [1:0] ym_sel_n;
  logic [2:0] border;

  int errors = 0;
  int checks = 0;

  logic mon_en = 1'b0;
  logic glitch = 1'b0;
  time  last_edge = 0;

  localparam int SHORT_P = 200;
  localparam int LONG_P  = 410;

  ym_multi_ctrl #(.NUM_CHIPS(2), .CNT_W(10), .FRAME_THRESH(300)) dut (
    .cpu_clock(cpu_clock), .reset(reset),
    .a0(a0), .a1(a1), .a14(a14), .a15(a15),
    .m1(m1), .iorq(iorq), .wr(wr), .int_n(int_n), .d(d),
    .bc1(bc1), .bdir(bdir), .ioge_c(ioge_c), .ym_clock(ym_clock),
    .ym_sel_n(ym_sel_n), .beeper(beeper), .tapeout(tapeout),
    .border(border), .turbo(turbo)
  );

  initial begin
    cpu_clock = 1'b0;
    forever #5 cpu_clock = ~cpu_clock;
  end

  always @(ym_clock) begin
    if (mon_en && ($time - last_edge) < 5) glitch = 1'b1;
    last_edge = $time;
  end

  task automatic tick();
    @(posedge cpu_clock);
    #1;
  endtask

  task automatic bus_idle();
    iorq = 1'b1; wr = 1'b1; m1 = 1'b1;
    a15 = 1'b0; a14 = 1'b0; a1 = 1'b1; a0 = 1'b1;
    d = 8'h00;
  endtask

  task automatic io_start(input logic [15:0] port, input logic [7:0] dv);
    a15 = port[15]; a14 = port[14]; a1 = port[1]; a0 = port[0];
    d = dv; iorq = 1'b0; wr = 1'b0; m1 = 1'b1;
  endtask

  task automatic int_pulse();
    int_n = 1'b0;
    repeat (4) tick();
    int_n = 1'b1;
  endtask

  task automatic frames(input int period, input int n);
    repeat (n) begin
      int_pulse();
      repeat (period - 4) tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #20;
    checks++; if (ym_sel_n !== 2'b10) begin errors++; $display("FAIL reset_sel: got %b expected 10", ym_sel_n); end
    checks++; if ({beeper, tapeout, border} !== 5'b0) begin errors++; $display("FAIL reset_fe: got %b expected 00000", {beeper, tapeout, border}); end
    checks++; if (turbo !== 1'b0) begin errors++; $display("FAIL reset_turbo: got %b expected 0", turbo); end
    checks++; if (ym_clock !== cpu_clock) begin errors++; $display("FAIL reset_ymclk: got %b expected %b", ym_clock, cpu_clock); end
    io_start(16'hFFFD, 8'h00);
    #1;
    checks++; if ({bc1, bdir, ioge_c} !== 3'b111) begin errors++; $display("FAIL reset_decode: got %b expected 111", {bc1, bdir, ioge_c}); end
    bus_idle();
    #1;
    checks++; if ({bc1, bdir, ioge_c} !== 3'b000) begin errors++; $display("FAIL reset_idle: got %b expected 000", {bc1, bdir, ioge_c}); end
    tick();
    reset = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_selector();
    logic [7:0] vals [4];
    logic [1:0] exp_sel [4];
    vals = '{8'hFE, 8'hFD, 8'h07, 8'hFF};
    exp_sel = '{2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      io_start(16'hFFFD, vals[i]);
      #1;
      checks++; if ({bc1, bdir} !== 2'b11) begin errors++; $display("FAIL sel_strobe[%0d]: got %b expected 11", i, {bc1, bdir}); end
      repeat (2) tick();
      checks++; if (ym_sel_n !== exp_sel[i]) begin errors++; $display("FAIL sel_write[%0d]: got %b expected %b", i, ym_sel_n, exp_sel[i]); end
      tick();
      bus_idle();
      repeat (3) tick();
    end
    // read of the data register: bc1 only
    a15 = 1'b1; a14 = 1'b1; a1 = 1'b0; a0 = 1'b1; iorq = 1'b0; wr = 1'b1;
    #1;
    checks++; if ({bc1, bdir, ioge_c} !== 3'b101) begin errors++; $display("FAIL sel_read: got %b expected 101", {bc1, bdir, ioge_c}); end
    bus_idle();
    repeat (2) tick();
  endtask

  task automatic test_fe_port();
    io_start(16'h00FE, 8'h1D);
    #1;
    checks++; if ({bc1, bdir} !== 2'b00) begin errors++; $display("FAIL fe_nodecode: got %b expected 00", {bc1, bdir}); end
    repeat (4) tick();
    d = 8'h00;
    repeat (6) tick();
    bus_idle();
    repeat (3) tick();
    checks++; if ({beeper, tapeout, border} !== 5'b11101) begin errors++; $display("FAIL fe_held: got %b expected 11101", {beeper, tapeout, border}); end
    checks++; if (ym_sel_n !== 2'b10) begin errors++; $display("FAIL fe_sel_kept: got %b expected 10", ym_sel_n); end
  endtask

  task automatic test_simultaneous();
    io_start(16'hFFFC, 8'hFE);
    repeat (3) tick();
    bus_idle();
    repeat (3) tick();
    checks++; if (ym_sel_n !== 2'b01) begin errors++; $display("FAIL simul_sel: got %b expected 01", ym_sel_n); end
    checks++; if ({beeper, tapeout, border} !== 5'b11110) begin errors++; $display("FAIL simul_fe: got %b expected 11110", {beeper, tapeout, border}); end
  endtask

  task automatic test_turbo_switch();
    logic s1, s2, s3;
    frames(SHORT_P, 4);
    checks++; if (turbo !== 1'b0) begin errors++; $display("FAIL turbo_short: got %b expected 0", turbo); end
    frames(LONG_P, 2);
    checks++; if (turbo !== 1'b0) begin errors++; $display("FAIL turbo_one_long: got %b expected 0", turbo); end
    glitch = 1'b0;
    mon_en = 1'b1;
    int_pulse();
    repeat (10) tick();
    checks++; if (turbo !== 1'b1) begin errors++; $display("FAIL turbo_two_long: got %b expected 1", turbo); end
    s1 = ym_clock; tick();
    s2 = ym_clock; tick();
    s3 = ym_clock;
    mon_en = 1'b0;
    checks++; if (s1 === s2 || s2 === s3) begin errors++; $display("FAIL turbo_div2: got %b%b%b expected alternating", s1, s2, s3); end
    checks++; if (glitch !== 1'b0) begin errors++; $display("FAIL turbo_glitch: got %b expected 0", glitch); end
  endtask

  task automatic test_single_long();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (turbo !== 1'b0) begin errors++; $display("FAIL long_after_reset: got %b expected 0", turbo); end
    frames(SHORT_P, 3);
    frames(LONG_P, 1);
    frames(SHORT_P, 2);
    int_pulse();
    repeat (10) tick();
    checks++; if (turbo !== 1'b0) begin errors++; $display("FAIL long_isolated: got %b expected 0", turbo); end
  endtask

  task automatic test_saturation();
    repeat (1100) tick();
    int_pulse();
    repeat (10) tick();
    checks++; if (turbo !== 1'b0) begin errors++; $display("FAIL sat_first: got %b expected 0", turbo); end
    repeat (1100) tick();
    int_pulse();
    repeat (10) tick();
    checks++; if (turbo !== 1'b1) begin errors++; $display("FAIL sat_second: got %b expected 1", turbo); end
  endtask

  task automatic test_reset_mid();
    io_start(16'hFFFD, 8'hFE);
    repeat (3) tick();
    bus_idle();
    tick();
    io_start(16'h00FE, 8'h10);
    repeat (3) tick();
    bus_idle();
    repeat (3) tick();
    checks++; if ({ym_sel_n, beeper, turbo} !== 4'b0111) begin errors++; $display("FAIL mid_setup: got %b expected 0111", {ym_sel_n, beeper, turbo}); end
    repeat (50) tick();
    reset = 1'b0;
    #1;
    checks++; if (turbo !== 1'b0) begin errors++; $display("FAIL mid_turbo: got %b expected 0", turbo); end
    checks++; if (ym_sel_n !== 2'b10) begin errors++; $display("FAIL mid_sel: got %b expected 10", ym_sel_n); end
    checks++; if (beeper !== 1'b0) begin errors++; $display("FAIL mid_beeper: got %b expected 0", beeper); end
    checks++; if (ym_clock !== cpu_clock) begin errors++; $display("FAIL mid_ymclk_hi: got %b expected %b", ym_clock, cpu_clock); end
    #5;
    checks++; if (ym_clock !== cpu_clock) begin errors++; $display("FAIL mid_ymclk_lo: got %b expected %b", ym_clock, cpu_clock); end
    tick();
    reset = 1'b1;
    repeat (10) tick();
    checks++; if (turbo !== 1'b0) begin errors++; $display("FAIL mid_pend_cleared: got %b expected 0", turbo); end
  endtask

  initial begin
    reset = 1'b0;
    int_n = 1'b1;
    bus_idle();
    test_reset();
    test_selector();
    test_fe_port();
    test_simultaneous();
    test_turbo_switch();
    test_single_long();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
